// File: rtl/toggle_pulse_rx_pkg.sv
// Shared constants and types for the toggle-based pulse crossing (sender and receiver sides).
// The counter ceiling is derived from the counter width so both ends agree on capacity.
package toggle_pulse_rx_pkg;

   localparam int TPR_SYNC_STAGES_DEF = 2;
   localparam int TPR_CNT_W_DEF       = 4;

   typedef enum logic [1:0] {
      CNT_HOLD,
      CNT_INC,
      CNT_DEC
   } cnt_op_e;

   function automatic int unsigned tpr_cnt_max(input int unsigned cnt_w);
      return (32'd1 << cnt_w) - 32'd1;
   endfunction

endpackage

// File: rtl/toggle_pulse_rx_if.sv
// Event drain interface of the toggle pulse receiver: valid/ready pop plus status and overflow clear.
interface toggle_pulse_rx_if
   import toggle_pulse_rx_pkg::*;
#(
   parameter int CNT_W = TPR_CNT_W_DEF
);

   logic             ev_valid;
   logic             ev_ready;
   logic [CNT_W-1:0] pend_cnt;
   logic             ovf;
   logic             ovf_clr;

   modport master (
      output ev_valid,
      output pend_cnt,
      output ovf,
      input  ev_ready,
      input  ovf_clr
   );

   modport slave (
      input  ev_valid,
      input  pend_cnt,
      input  ovf,
      output ev_ready,
      output ovf_clr
   );

endinterface

// File: rtl/toggle_pulse_rx_bit_sync.sv
// Generic N-flop single-bit synchroniser with asynchronous active-low reset.
module bit_sync
   import toggle_pulse_rx_pkg::*;
#(
   parameter int STAGES = TPR_SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_pulse_rx.sv
// Receive end of the toggle pulse crossing: synchronise the toggle level, turn each level change
// into one event, and hold events in a saturating pending counter drained over valid/ready.
module toggle_pulse_rx
   import toggle_pulse_rx_pkg::*;
#(
   parameter int SYNC_STAGES = TPR_SYNC_STAGES_DEF,
   parameter int CNT_W       = TPR_CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tog_in,
   output logic                     ack_lvl,
   toggle_pulse_rx_if.master        ev_if
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(tpr_cnt_max(CNT_W));

   logic             sync_lvl;
   logic             hist;
   logic             inc;
   logic             pop;
   logic [CNT_W-1:0] pend_cnt;
   logic             ovf;
   cnt_op_e          cnt_op;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_tog_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tog_in),
      .q     (sync_lvl)
   );

   // History flop holds the last accepted level; it doubles as the acknowledge back to the sender.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= 1'b0;
      end else begin
         hist <= sync_lvl;
      end
   end

   assign inc = sync_lvl ^ hist;
   assign pop = ev_if.ev_valid & ev_if.ev_ready;

   always_comb begin
      cnt_op = CNT_HOLD;
      if (inc && !pop) begin
         cnt_op = CNT_INC;
      end else if (!inc && pop) begin
         cnt_op = CNT_DEC;
      end
   end

   // Saturating counter; a dropped event sets ovf, and a simultaneous set beats ovf_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         if (ev_if.ovf_clr) begin
            ovf <= 1'b0;
         end
         case (cnt_op)
            CNT_INC: begin
               if (pend_cnt == CNT_MAX) begin
                  ovf <= 1'b1;
               end else begin
                  pend_cnt <= pend_cnt + CNT_W'(1);
               end
            end
            CNT_DEC: pend_cnt <= pend_cnt - CNT_W'(1);
            default: pend_cnt <= pend_cnt;
         endcase
      end
   end

   assign ev_if.ev_valid = (pend_cnt != '0);
   assign ev_if.pend_cnt = pend_cnt;
   assign ev_if.ovf      = ovf;
   assign ack_lvl        = hist;

endmodule
